calc_input_sequencer: RTL and testbench
=======================================

// Module: calc_input_sequencer
// PURPOSE
//  Responder side of the calculator front-panel protocol: converts raw ENTER key presses plus SW[7:0]
//  into opcode / operand-A / operand-B captures, an execute strobe, and per-press multiply step strobes.
//  Sits in project5Top between KEY/SW pins and the function unit; its state drives LED debug display.
// PARAMETERS
//  HOLDOFF    2  clocks after an accepted press during which further falling edges are ignored (>=1)
//  MUL_STEPS  8  step presses required after EXEC for the multiply opcode before returning to LOAD_OP
// PORTS
//  CLOCK_50    in   1  system clock, all flops rising-edge
//  KEY0        in   1  asynchronous active-low reset (KEY[0] at top)
//  enter_n     in   1  raw ENTER key (KEY[1]), active low, asynchronous to CLOCK_50
//  sw          in   8  data switches SW[7:0]
//  opcode      out  4  captured command
//  op_a        out  8  captured operand A
//  op_b        out  8  captured operand B (0 for single-operand opcodes)
//  exec_start  out  1  one-cycle pulse: operands valid, function unit evaluates
//  mul_step    out  1  one-cycle pulse per accepted press in MUL_STEP
//  step_cnt    out  3  multiply steps issued so far
//  state       out  3  FSM state encoding (debug / LED)
//  busy        out  1  high in EXEC and MUL_STEP
//  err         out  1  sticky invalid-opcode flag, cleared by next valid opcode capture
// BEHAVIOUR
//  - Reset (KEY0=0, async): all outputs 0, state=LOAD_OP; sync flops reset to 1 (released) so no press at release.
//  - Press detect: 2-flop synchroniser on enter_n; press = synced 1->0 edge, HOLDOFF counter idle; one-cycle
//    internal pulse, latency 3 clocks from enter_n fall. Minimum low width 1 clock. Holdoff restarts on accept.
//  - States: LOAD_OP=0, LOAD_A=1, LOAD_B=2, EXEC=3, MUL_STEP=4; codes 5-7 unused -> LOAD_OP.
//  - LOAD_OP+press: sw[3:0]>4'hC -> err=1, stay; else opcode<=sw[3:0], err<=0, -> LOAD_A. sw[7:4] ignored.
//  - LOAD_A+press: op_a<=sw; opcode 4 (NOT) or 7 (NEG) -> op_b<=0, -> EXEC; else -> LOAD_B.
//  - LOAD_B+press: op_b<=sw, -> EXEC.
//  - EXEC: exactly one cycle, exec_start=1; opcode C -> MUL_STEP, step_cnt<=0; else -> LOAD_OP.
//  - MUL_STEP+press: mul_step=1 same cycle, step_cnt++; press number MUL_STEPS -> LOAD_OP, step_cnt<=0.
//  - Press coinciding with EXEC is dropped (cannot occur while HOLDOFF>=1 covers that cycle).
//  - opcode/op_a/op_b hold their values until overwritten by a later capture; never cleared except by reset.
//  - Reset mid-operation: immediate LOAD_OP, step_cnt=0, no exec_start/mul_step pulse on release.
//  - Holdoff counter saturates at 0; width ceil(log2(HOLDOFF+1)).
// STRUCTURE
//  - calc_pkg: opcode localparams (OP_AND..OP_MUL=4'hC, OP_MAX), state encodings, single-operand opcode list.
//  - Sub-module key_press_detect: synchroniser + falling-edge + HOLDOFF lockout, output press pulse.
//  - Top: FSM, capture registers, step counter; all outputs registered except exec_start/mul_step (decoded).
// TESTING
//  1 Reset: KEY0 low 3ns, enter_n=1 -> state=0, opcode/op_a/op_b=0, no pulses for 10 clocks after release.
//  2 ADD: presses with sw=05,5C,15 -> opcode=5, op_a=5C, op_b=15, single exec_start, state returns to 0.
//  3 NOT: presses with sw=04,05 -> exec_start after 2nd press, op_b=00, state 0; 3rd press loads new opcode.
//  4 MUL: sw=0C,66,2D then 8 presses -> one exec_start, 8 mul_step pulses, step_cnt 1..8 wrap to 0,
//    busy high throughout, state 0 after 8th; 9th press captures opcode.
//  5 Invalid: sw=0F press -> err=1, state stays 0; sw=01 press -> err=0, opcode=1, state=1.
//  6 Reset mid-MUL after 3 steps -> state=0, step_cnt=0 immediately; two presses 1 clock apart -> one accept.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcode and state encodings for the calculator front-panel input sequencer.
package calc_pkg;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_NAND = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_NEG  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'hA;
  localparam logic [3:0] OP_ROR  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_MAX  = OP_MUL;

  typedef enum logic [2:0] {
    ST_LOAD_OP  = 3'd0,
    ST_LOAD_A   = 3'd1,
    ST_LOAD_B   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_MUL_STEP = 3'd4
  } state_e;

  // Opcodes that take only operand A; operand B is forced to zero.
  function automatic logic is_single_op(input logic [3:0] op);
    return (op == OP_NOT) || (op == OP_NEG);
  endfunction

endpackage

// File: rtl/key_press_detect.sv
// Synchronises a raw active-low key, detects its falling edge and locks out
// further edges for HOLDOFF clocks after each accepted press.
module key_press_detect #(
  parameter int HOLDOFF = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic press_o
);

  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  logic          s1_q, s2_q, s3_q;
  logic [HW-1:0] hold_q, hold_d;

  // Sync flops reset to released so reset deassertion never looks like a press.
  assign press_o = s3_q & ~s2_q & (hold_q == '0);

  always_comb begin
    hold_d = hold_q;
    if (press_o)             hold_d = HW'(HOLDOFF);
    else if (hold_q != '0)   hold_d = hold_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      s3_q   <= 1'b1;
      hold_q <= '0;
    end else begin
      s1_q   <= key_n_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/calc_input_sequencer.sv
// Turns ENTER presses plus SW[7:0] into opcode/operand captures, an execute
// strobe and per-press multiply step strobes for the calculator function unit.
module calc_input_sequencer
  import calc_pkg::*;
#(
  parameter int HOLDOFF   = 2,
  parameter int MUL_STEPS = 8
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       enter_n,
  input  logic [7:0] sw,
  output logic [3:0] opcode,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       exec_start,
  output logic       mul_step,
  output logic [2:0] step_cnt,
  output logic [2:0] state,
  output logic       busy,
  output logic       err
);

  state_e     state_q, state_d;
  logic       press;
  logic       busy_q, busy_d;
  logic       err_q;
  logic [3:0] opcode_q;
  logic [7:0] op_a_q, op_b_q;
  logic [2:0] step_q;
  logic       op_valid, last_step;

  key_press_detect #(.HOLDOFF(HOLDOFF)) u_kpd (
    .clk_i   (CLOCK_50),
    .rst_ni  (KEY0),
    .key_n_i (enter_n),
    .press_o (press)
  );

  assign op_valid  = (sw[3:0] <= OP_MAX);
  assign last_step = (step_q == 3'(MUL_STEPS - 1));

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) state_q <= ST_LOAD_OP;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD_OP:  if (press && op_valid) state_d = ST_LOAD_A;
      ST_LOAD_A:   if (press) state_d = is_single_op(opcode_q) ? ST_EXEC : ST_LOAD_B;
      ST_LOAD_B:   if (press) state_d = ST_EXEC;
      ST_EXEC:     state_d = (opcode_q == OP_MUL) ? ST_MUL_STEP : ST_LOAD_OP;
      ST_MUL_STEP: if (press && last_step) state_d = ST_LOAD_OP;
      default:     state_d = ST_LOAD_OP;
    endcase
  end

  always_comb begin
    exec_start = (state_q == ST_EXEC);
    mul_step   = press && (state_q == ST_MUL_STEP);
    busy_d     = (state_d == ST_EXEC) || (state_d == ST_MUL_STEP);
  end

  // Capture registers hold until overwritten; only reset clears them.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      opcode_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      err_q    <= 1'b0;
      step_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      case (state_q)
        ST_LOAD_OP: if (press) begin
          if (op_valid) begin
            opcode_q <= sw[3:0];
            err_q    <= 1'b0;
          end else begin
            err_q    <= 1'b1;
          end
        end
        ST_LOAD_A: if (press) begin
          op_a_q <= sw;
          if (is_single_op(opcode_q)) op_b_q <= '0;
        end
        ST_LOAD_B:   if (press) op_b_q <= sw;
        ST_EXEC:     step_q <= '0;
        ST_MUL_STEP: if (press) step_q <= last_step ? 3'd0 : step_q + 3'd1;
        default: ;
      endcase
    end
  end

  assign opcode   = opcode_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign step_cnt = step_q;
  assign state    = state_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Bench for calc_input_sequencer: vector table of presses plus hand sequences
// for multiply stepping, mid-operation reset and holdoff double presses.
module tb_calc_input_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       KEY0     = 1'b0;
  logic       enter_n  = 1'b1;
  logic [7:0] sw       = 8'h00;
  logic [3:0] opcode;
  logic [7:0] op_a, op_b;
  logic       exec_start, mul_step, busy, err;
  logic [2:0] step_cnt, state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] sw;
    logic [2:0] st;
    logic       err;
    logic [3:0] op;
    logic       ex;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } exec_t;

  exec_t      eq[$];
  logic [2:0] mq[$];
  vec_t       vt[15];

  calc_input_sequencer #(.HOLDOFF(2), .MUL_STEPS(8)) dut (
    .CLOCK_50   (CLOCK_50),
    .KEY0       (KEY0),
    .enter_n    (enter_n),
    .sw         (sw),
    .opcode     (opcode),
    .op_a       (op_a),
    .op_b       (op_b),
    .exec_start (exec_start),
    .mul_step   (mul_step),
    .step_cnt   (step_cnt),
    .state      (state),
    .busy       (busy),
    .err        (err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match a previously pushed expectation.
  always @(negedge CLOCK_50) begin
    if (exec_start) begin
      if (eq.size() == 0) chk("unexpected_exec_start", 32'd1, 32'd0);
      else begin
        exec_t e;
        e = eq.pop_front();
        chk("exec_opcode", {28'd0, opcode}, {28'd0, e.op});
        chk("exec_op_a",   {24'd0, op_a},   {24'd0, e.a});
        chk("exec_op_b",   {24'd0, op_b},   {24'd0, e.b});
      end
    end
    if (mul_step) begin
      if (mq.size() == 0) chk("unexpected_mul_step", 32'd1, 32'd0);
      else begin
        logic [2:0] s;
        s = mq.pop_front();
        chk("mul_step_cnt_before", {29'd0, step_cnt}, {29'd0, s});
        chk("mul_step_busy", {31'd0, busy}, 32'd1);
      end
    end
  end

  // Press held low 2 clocks, then enough idle time for holdoff and EXEC to clear.
  task automatic press(input logic [7:0] v);
    @(posedge CLOCK_50); #1;
    sw = v; enter_n = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1 enter_n = 1'b1;
    repeat (6) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, pending exec %0d mul %0d", eq.size(), mq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{8'h05, 3'd1, 1'b0, 4'h5, 1'b0, 8'h00, 8'h00};
    vt[1]  = '{8'h5C, 3'd2, 1'b0, 4'h5, 1'b0, 8'h00, 8'h00};
    vt[2]  = '{8'h15, 3'd0, 1'b0, 4'h5, 1'b1, 8'h5C, 8'h15};
    vt[3]  = '{8'h04, 3'd1, 1'b0, 4'h4, 1'b0, 8'h00, 8'h00};
    vt[4]  = '{8'h05, 3'd0, 1'b0, 4'h4, 1'b1, 8'h05, 8'h00};
    vt[5]  = '{8'h03, 3'd1, 1'b0, 4'h3, 1'b0, 8'h00, 8'h00};
    vt[6]  = '{8'h11, 3'd2, 1'b0, 4'h3, 1'b0, 8'h00, 8'h00};
    vt[7]  = '{8'h22, 3'd0, 1'b0, 4'h3, 1'b1, 8'h11, 8'h22};
    vt[8]  = '{8'h0F, 3'd0, 1'b1, 4'h3, 1'b0, 8'h00, 8'h00};
    vt[9]  = '{8'hFD, 3'd0, 1'b1, 4'h3, 1'b0, 8'h00, 8'h00};
    vt[10] = '{8'hF1, 3'd1, 1'b0, 4'h1, 1'b0, 8'h00, 8'h00};
    vt[11] = '{8'hAA, 3'd2, 1'b0, 4'h1, 1'b0, 8'h00, 8'h00};
    vt[12] = '{8'hBB, 3'd0, 1'b0, 4'h1, 1'b1, 8'hAA, 8'hBB};
    vt[13] = '{8'h07, 3'd1, 1'b0, 4'h7, 1'b0, 8'h00, 8'h00};
    vt[14] = '{8'h80, 3'd0, 1'b0, 4'h7, 1'b1, 8'h80, 8'h00};

    // Reset state
    #1;
    chk("rst_state",  {29'd0, state},  32'd0);
    chk("rst_opcode", {28'd0, opcode}, 32'd0);
    chk("rst_op_a",   {24'd0, op_a},   32'd0);
    chk("rst_op_b",   {24'd0, op_b},   32'd0);
    chk("rst_busy_err", {30'd0, busy, err}, 32'd0);
    #2 KEY0 = 1'b1;
    idle(10);
    chk("post_rst_state", {29'd0, state}, 32'd0);

    // Table: ADD, NOT, reload, invalid opcodes, NEG
    for (int i = 0; i < 15; i++) begin
      if (vt[i].ex) eq.push_back('{vt[i].op, vt[i].a, vt[i].b});
      press(vt[i].sw);
      chk($sformatf("v%0d_state", i),  {29'd0, state},  {29'd0, vt[i].st});
      chk($sformatf("v%0d_err", i),    {31'd0, err},    {31'd0, vt[i].err});
      chk($sformatf("v%0d_opcode", i), {28'd0, opcode}, {28'd0, vt[i].op});
      chk($sformatf("v%0d_busy", i),   {31'd0, busy},   32'd0);
    end

    // MUL: operands, exec, then 8 step presses
    press(8'h0C);
    press(8'h66);
    eq.push_back('{4'hC, 8'h66, 8'h2D});
    press(8'h2D);
    chk("mul_enter_state", {29'd0, state}, 32'd4);
    chk("mul_enter_busy",  {31'd0, busy},  32'd1);
    chk("mul_enter_cnt",   {29'd0, step_cnt}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      mq.push_back(3'(i));
      press(8'h55);
      chk($sformatf("mul%0d_cnt", i),   {29'd0, step_cnt}, (i + 1) % 8);
      chk($sformatf("mul%0d_state", i), {29'd0, state},    (i == 7) ? 32'd0 : 32'd4);
      chk($sformatf("mul%0d_busy", i),  {31'd0, busy},     (i == 7) ? 32'd0 : 32'd1);
    end
    press(8'h06);
    chk("mul_after_state",  {29'd0, state},  32'd1);
    chk("mul_after_opcode", {28'd0, opcode}, 32'd6);
    chk("mul_after_op_b_held", {24'd0, op_b}, 32'h2D);

    // Reset mid-MUL after 3 steps
    @(posedge CLOCK_50); #1 KEY0 = 1'b0;
    #3 KEY0 = 1'b1;
    idle(2);
    press(8'h0C);
    press(8'h01);
    eq.push_back('{4'hC, 8'h01, 8'h02});
    press(8'h02);
    for (int i = 0; i < 3; i++) begin
      mq.push_back(3'(i));
      press(8'h00);
    end
    chk("mid_cnt3", {29'd0, step_cnt}, 32'd3);
    @(posedge CLOCK_50); #2 KEY0 = 1'b0;
    #2;
    chk("midrst_state", {29'd0, state},    32'd0);
    chk("midrst_cnt",   {29'd0, step_cnt}, 32'd0);
    chk("midrst_busy",  {31'd0, busy},     32'd0);
    chk("midrst_opcode", {28'd0, opcode},  32'd0);
    #3 KEY0 = 1'b1;
    idle(10);
    chk("midrst_idle_state", {29'd0, state}, 32'd0);

    // Two presses one clock apart: holdoff lets only the first through
    @(posedge CLOCK_50); #1 sw = 8'h03; enter_n = 1'b0;
    @(posedge CLOCK_50); #1 enter_n = 1'b1;
    @(posedge CLOCK_50); #1 enter_n = 1'b0;
    @(posedge CLOCK_50); #1 enter_n = 1'b1;
    idle(8);
    chk("dbl_state",  {29'd0, state},  32'd1);
    chk("dbl_opcode", {28'd0, opcode}, 32'd3);

    idle(4);
    chk("pending_exec", eq.size(), 32'd0);
    chk("pending_mul",  mq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
